// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame sequencer (clear, pose latch, render handshake, vblank swap)
// and sole owner of the framebuffer write port. Define FRAME_SCHEDULER_CLEAR_EN for the sky-colour clear sweep.
module frame_scheduler #(
  parameter int         SCREEN_W  = 320,
  parameter int         SCREEN_H  = 240,
  parameter logic [2:0] SKY_COLOR = 3'd1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vblank,
  input  logic [31:0] player_pos_in,
  input  logic [9:0]  player_angle_in,
  output logic [31:0] player_pos_out,
  output logic [9:0]  player_angle_out,
  output logic        render_ack,
  input  logic        render_done,
  input  logic        r_we,
  input  logic [16:0] r_coords,
  input  logic [2:0]  r_color,
  output logic        fb_we,
  output logic [16:0] fb_coords,
  output logic [2:0]  fb_color,
  output logic        fb_back,
  output logic        fb_front,
  output logic [15:0] frame_count,
  output logic [7:0]  dropped
);

  typedef enum logic [2:0] {
    ST_CLEAR       = 3'd0,
    ST_LATCH       = 3'd1,
    ST_ACK         = 3'd2,
    ST_RENDER      = 3'd3,
    ST_WAIT_VBLANK = 3'd4
  } state_t;

`ifdef FRAME_SCHEDULER_CLEAR_EN
  localparam state_t     RESTART_STATE = ST_CLEAR;
  localparam logic [8:0] X_LAST        = 9'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST        = 8'(SCREEN_H - 1);
  logic [8:0] cx_r;
  logic [7:0] cy_r;
`else
  localparam state_t     RESTART_STATE = ST_LATCH;
`endif

  state_t      state_r;
  logic        vblank_q_r;
  logic        fb_we_r;
  logic [16:0] fb_coords_r;
  logic [2:0]  fb_color_r;
  logic        render_ack_r;
  logic        fb_front_r;
  logic [15:0] frame_count_r;
  logic [7:0]  dropped_r;
  logic [31:0] player_pos_r;
  logic [9:0]  player_angle_r;

  logic vblank_rise_s;
  logic drop_s;

  assign vblank_rise_s = vblank & ~vblank_q_r;
  // An edge only produces a swap while waiting for it; anywhere else it is a missed frame.
  assign drop_s        = vblank_rise_s && (state_r != ST_WAIT_VBLANK);

  // Frame sequencer with all outputs registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r        <= RESTART_STATE;
`ifdef FRAME_SCHEDULER_CLEAR_EN
      cx_r           <= 9'd0;
      cy_r           <= 8'd0;
`endif
      vblank_q_r     <= 1'b0;
      fb_we_r        <= 1'b0;
      fb_coords_r    <= 17'd0;
      fb_color_r     <= 3'd0;
      render_ack_r   <= 1'b0;
      fb_front_r     <= 1'b0;
      frame_count_r  <= 16'd0;
      dropped_r      <= 8'd0;
      player_pos_r   <= 32'd0;
      player_angle_r <= 10'd0;
    end else begin
      vblank_q_r   <= vblank;
      fb_we_r      <= 1'b0;
      render_ack_r <= 1'b0;
      if (drop_s && (dropped_r != 8'hFF)) begin
        dropped_r <= dropped_r + 8'd1;
      end
      case (state_r)
`ifdef FRAME_SCHEDULER_CLEAR_EN
        ST_CLEAR: begin
          fb_we_r     <= 1'b1;
          fb_coords_r <= {cx_r, cy_r};
          fb_color_r  <= SKY_COLOR;
          if (cx_r == X_LAST) begin
            cx_r <= 9'd0;
            if (cy_r == Y_LAST) begin
              cy_r    <= 8'd0;
              state_r <= ST_LATCH;
            end else begin
              cy_r <= cy_r + 8'd1;
            end
          end else begin
            cx_r <= cx_r + 9'd1;
          end
        end
`endif
        ST_LATCH: begin
          player_pos_r   <= player_pos_in;
          player_angle_r <= player_angle_in;
          state_r        <= ST_ACK;
        end
        ST_ACK: begin
          render_ack_r <= 1'b1;
          state_r      <= ST_RENDER;
        end
        ST_RENDER: begin
          fb_we_r     <= r_we;
          fb_coords_r <= r_coords;
          fb_color_r  <= r_color;
          if (render_done) begin
            state_r <= ST_WAIT_VBLANK;
          end
        end
        ST_WAIT_VBLANK: begin
          if (vblank_rise_s) begin
            fb_front_r    <= ~fb_front_r;
            frame_count_r <= frame_count_r + 16'd1;
            state_r       <= RESTART_STATE;
          end
        end
        default: begin
          state_r <= RESTART_STATE;
        end
      endcase
    end
  end

  assign player_pos_out   = player_pos_r;
  assign player_angle_out = player_angle_r;
  assign render_ack       = render_ack_r;
  assign fb_we            = fb_we_r;
  assign fb_coords        = fb_coords_r;
  assign fb_color         = fb_color_r;
  assign fb_front         = fb_front_r;
  assign fb_back          = ~fb_front_r;
  assign frame_count      = frame_count_r;
  assign dropped          = dropped_r;

endmodule
